// File: rtl/standby_multi.sv
// Multi-channel clock-standby controller: per-channel hold counters driven by routed
// wakeup events, busy and force-on, with one latch-based clock gate per channel.
module standby_multi #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 2,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    wakeup,
  input  logic [N-1:0]    edge_mode,
  input  logic [CH*N-1:0] wake_mask,
  input  logic [CH-1:0]   idle,
  input  logic [CH-1:0]   force_on,
  input  logic [CW-1:0]   hold_cycles,
  input  logic            test_en,
  input  logic            cause_clr,
  output logic [CH-1:0]   clkout,
  output logic [CH-1:0]   clk_en,
  output logic [CH-1:0]   asleep,
  output logic [N-1:0]    wake_cause
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [N-1:0]  wakeup_q;
  logic [N-1:0]  ev;
  logic [N-1:0]  cause_hit;
  logic [N-1:0]  wake_cause_q;
  logic [N-1:0]  wake_cause_d;
  logic [CH-1:0] wake;
  logic [CH-1:0] asleep_q;
  logic [CH-1:0] en_lat;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  // Sampled even during reset so no spurious edge appears at reset release.
  always_ff @(posedge clk) begin
    wakeup_q <= wakeup;
  end

  // Event detect, wake conditions, enables and counter next-state.
  always_comb begin
    ev        = (edge_mode & (wakeup ^ wakeup_q)) | (~edge_mode & wakeup);
    cause_hit = '0;
    wake      = '0;
    clk_en    = '0;
    for (int c = 0; c < int'(CH); c++) begin
      cnt_d[c]  = cnt_q[c];
      wake[c]   = (|(ev & wake_mask[c*N +: N])) | ~idle[c] | force_on[c];
      clk_en[c] = reset | wake[c] | (cnt_q[c] != '0);
      if (wake[c]) begin
        cnt_d[c] = hold_cycles;
      end else if (cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - CW'(1);
      end
      if (asleep_q[c]) begin
        cause_hit = cause_hit | (ev & wake_mask[c*N +: N]);
      end
    end
    // A new cause in the same cycle as a clear survives the clear.
    wake_cause_d = (cause_clr ? '0 : wake_cause_q) | cause_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < int'(CH); c++) begin
        cnt_q[c] <= CNT_MAX;
      end
      asleep_q     <= '0;
      wake_cause_q <= '0;
    end else begin
      for (int c = 0; c < int'(CH); c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      asleep_q     <= ~clk_en;
      wake_cause_q <= wake_cause_d;
    end
  end

  // Latch-based gates: enable captured while clk is low, so clkout never glitches.
  always_latch begin
    if (!clk) begin
      en_lat = clk_en | {CH{test_en}};
    end
  end

  assign clkout     = {CH{clk}} & en_lat;
  assign asleep     = asleep_q;
  assign wake_cause = wake_cause_q;

endmodule
